pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined N-bit adder; successor to the single-bit full-adder cells.
//  Splits operands into SEG_W-bit segments and adds one segment per pipeline stage,
//  with each stage's carry registered into the next. Uses valid/ready handshakes on
//  input and output, so it can sit between streaming datapath blocks under backpressure.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of SEG_W
//  SEG_W   4   segment width; STAGES = WIDTH/SEG_W pipeline stages (>=1)
// PORTS
//  Clock_in        in   1      single clock, all logic on rising edge
//  Reset_in        in   1      synchronous, active-high reset
//  Data_in_A       in   WIDTH  operand A
//  Data_in_B       in   WIDTH  operand B
//  Data_in_C       in   1      carry-in
//  In_valid        in   1      input operands valid
//  In_ready        out  1      block accepts operands this cycle
//  Data_out_Sum    out  WIDTH  sum
//  Data_out_Carry  out  1      carry-out of MSB
//  Out_valid       out  1      result valid
//  Out_ready       in   1      downstream accepts result this cycle
// BEHAVIOUR
//  - Transfer on input when In_valid & In_ready; on output when Out_valid & Out_ready.
//  - advance = !Out_valid | Out_ready. In_ready = advance (combinational).
//  - Advance is a global enable: when it is 1, every stage shifts one place. When it
//    is 0, all stage registers hold, including data, carry and valid.
//  - Stage k (0..STAGES-1) adds segment k of A, segment k of B and the carry from
//    stage k-1 (Data_in_C for k=0). It registers the SEG_W-bit partial sum and carry.
//  - Unprocessed upper segments travel with the token in skew registers. Completed
//    lower sum segments are carried forward to the last stage.
//  - Latency: exactly STAGES cycles from input transfer to Out_valid, with no stalls.
//    Throughput is 1 result/cycle while Out_ready=1.
//  - Bubbles: a stage with valid=0 is overwritten on advance. Bubbles collapse only
//    through the global enable; no per-stage skid.
//  - Result = (A + B + C) mod 2^WIDTH. Data_out_Carry is bit WIDTH of the full sum.
//  - Output data is held stable while Out_valid=1 and Out_ready=0.
//  - Reset: all valid bits, partial sums, carries and skew registers go to 0.
//    Out_valid=0, Data_out_Sum=0 and Data_out_Carry=0 in the cycle after Reset_in is
//    sampled high. In_ready=1 during reset and after it, because Out_valid=0.
//  - Reset mid-operation discards all in-flight tokens. No result for them is emitted.
//  - Simultaneous input and output transfer in the same cycle is legal and is the
//    normal streaming case.
//  - STAGES=1 degenerates to one registered WIDTH-bit adder with handshake.
// CONFIGURATION
//  ADDSUB_EN defined:
//    - Adds input Data_in_Sub (1 bit, sampled with the operands) and output
//      Data_out_Ovf (1 bit, reset 0).
//    - Sub=1: B is inverted and the stage-0 carry-in is forced to 1; Data_in_C is
//      ignored. Result = A - B. Data_out_Carry = 1 means no borrow.
//    - Data_out_Ovf = signed two's-complement overflow of the WIDTH-bit result.
//      It is valid for both add and sub, computed in the last stage.
//    - The Sub flag travels with its token through the pipeline.
//  ADDSUB_EN undefined: both ports are absent; add only.
// TESTING
//  Use WIDTH=16, SEG_W=4 (latency 4) unless stated otherwise.
//  1. Reset: hold Reset_in for 2 cycles mid-stream with 3 tokens in flight. Required:
//     Out_valid=0, Sum=0, Carry=0; none of the 3 tokens appear afterwards.
//  2. Single op: A=0x00FF, B=0x0001, C=0. Required: 4 cycles later Out_valid=1,
//     Sum=0x0100, Carry=0. Also A=0xFFFF, B=0x0000, C=1: Sum=0x0000, Carry=1, which
//     checks carry rippling across all stages.
//  3. Streaming: 100 random tokens, In_valid=1, Out_ready=1. Required: one result per
//     cycle, in order, matching the reference model.
//  4. Backpressure: random Out_ready at 50% with random In_valid. Required: no token
//     lost or duplicated, output stable while stalled, In_ready==!Out_valid|Out_ready.
//  5. ADDSUB_EN: 0x8000-0x0001 gives 0x7FFF, Carry=1, Ovf=1; 0x0003-0x0005 gives
//     0xFFFE, Carry=0, Ovf=0; 0x7FFF+0x0001 (add) gives Ovf=1. Also interleave
//     add/sub tokens back-to-back.
//  6. Config sweep: WIDTH/SEG_W = 8/8 (STAGES=1) and 32/4. Required: latency equals
//     STAGES and results are correct under case 3.

Source files
------------

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   Pipelined WIDTH-bit adder. The operands are split into SEG_W-bit segments.
//   Pipeline stage k adds segment k of A and B together with the carry that
//   stage k-1 registered. The upper operand segments that have not been added
//   yet move down the pipeline with their token in skew registers. The lower
//   sum segments that are already finished are carried forward to the last
//   stage. The last stage presents the full WIDTH-bit sum and the carry out.
//
//   A single global enable (advance) moves every stage one place at a time.
//   Tokens with valid=0 are bubbles. A bubble disappears only when it is
//   overwritten on an advance.
//
// Parameters:
//   WIDTH           operand and sum width; must be a multiple of SEG_W
//   SEG_W           segment width; STAGES = WIDTH/SEG_W
//
// Ports:
//   Clock_in        single clock; every flop updates on the rising edge
//   Reset_in        synchronous reset, active high
//   Data_in_A/B     operands
//   Data_in_C       carry-in
//   Data_in_Sub     (ADDSUB_EN only) 1 = compute A - B; Data_in_C is ignored
//   In_valid        operands valid
//   In_ready        block accepts operands this cycle (= !Out_valid | Out_ready)
//   Data_out_Sum    sum, modulo 2^WIDTH
//   Data_out_Carry  bit WIDTH of the full sum (for subtraction: 1 = no borrow)
//   Data_out_Ovf    (ADDSUB_EN only) signed two's-complement overflow
//   Out_valid       result valid
//   Out_ready       downstream accepts the result this cycle
//
// Build option:
//   ADDSUB_EN       define this macro to add the Data_in_Sub / Data_out_Ovf
//                   add/subtract mode. When it is undefined the block only adds.
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             Clock_in,
    input  logic             Reset_in,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
`ifdef ADDSUB_EN
    input  logic             Data_in_Sub,
    output logic             Data_out_Ovf,
`endif
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry,
    output logic             Out_valid,
    input  logic             Out_ready
);

    localparam int STAGES = WIDTH / SEG_W;

    // Stage registers. Stage STAGES-1 is the output register.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
`ifdef ADDSUB_EN
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             src_sub;
`endif

    logic             advance;
    logic [WIDTH-1:0] b_in_eff;
    logic             c_in_eff;

    // Source of each stage's inputs: the ports for stage 0, otherwise the
    // registers of the stage before it.
    logic             src_valid;
    logic             src_c;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [SEG_W:0]   seg;
    int               kp;

    assign advance = !Out_valid || Out_ready;
    assign In_ready = advance;

    // Subtraction is computed as A + ~B + 1. B is inverted here, before it
    // enters the pipeline, so the skew registers hold the B that the adder
    // uses, and the last stage can read the sign bits directly.
`ifdef ADDSUB_EN
    assign b_in_eff = Data_in_Sub ? ~Data_in_B : Data_in_B;
    assign c_in_eff = Data_in_Sub ? 1'b1 : Data_in_C;
`else
    assign b_in_eff = Data_in_B;
    assign c_in_eff = Data_in_C;
`endif

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            sum_d[k]   = sum_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
`ifdef ADDSUB_EN
            sub_d[k]   = sub_q[k];
`endif
        end
`ifdef ADDSUB_EN
        ovf_d   = ovf_q;
        src_sub = 1'b0;
`endif
        src_valid = 1'b0;
        src_c     = 1'b0;
        src_a     = '0;
        src_b     = '0;
        src_sum   = '0;
        seg       = '0;
        kp        = 0;

        // When advance is 0, every stage keeps the value it already holds.
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                kp = (k == 0) ? 0 : k - 1;
                if (k == 0) begin
                    src_valid = In_valid;
                    src_c     = c_in_eff;
                    src_a     = Data_in_A;
                    src_b     = b_in_eff;
                    src_sum   = '0;
`ifdef ADDSUB_EN
                    src_sub   = Data_in_Sub;
`endif
                end else begin
                    src_valid = valid_q[kp];
                    src_c     = carry_q[kp];
                    src_a     = a_q[kp];
                    src_b     = b_q[kp];
                    src_sum   = sum_q[kp];
`ifdef ADDSUB_EN
                    src_sub   = sub_q[kp];
`endif
                end

                seg = {1'b0, src_a[k*SEG_W +: SEG_W]}
                    + {1'b0, src_b[k*SEG_W +: SEG_W]}
                    + {{SEG_W{1'b0}}, src_c};

                valid_d[k] = src_valid;
                carry_d[k] = seg[SEG_W];
                sum_d[k]   = src_sum;
                sum_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
                a_d[k]     = src_a;
                b_d[k]     = src_b;
`ifdef ADDSUB_EN
                sub_d[k]   = src_sub;
                // Signed overflow happens when both operands have the same
                // sign and the result has the other sign. The result MSB is
                // produced in this stage, so the flag is computed here.
                if (k == STAGES - 1) begin
                    ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                            (seg[SEG_W-1] != src_a[WIDTH-1]);
                end
`endif
            end
        end
    end

    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
`ifdef ADDSUB_EN
                sub_q[k]   <= 1'b0;
`endif
            end
`ifdef ADDSUB_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
`ifdef ADDSUB_EN
                sub_q[k]   <= sub_d[k];
`endif
            end
`ifdef ADDSUB_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign Out_valid      = valid_q[STAGES-1];
    assign Data_out_Sum   = sum_q[STAGES-1];
    assign Data_out_Carry = carry_q[STAGES-1];
`ifdef ADDSUB_EN
    assign Data_out_Ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int W      = 16;
    localparam int S      = 4;
    localparam int STAGES = W / S;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         ovf_out;
    logic         out_valid;
    logic         out_ready;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
    int   cyc      = 0;
    int   n_out    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder #(.WIDTH(W), .SEG_W(S)) dut (
        .Clock_in       (clk),
        .Reset_in       (rst),
        .Data_in_A      (a_in),
        .Data_in_B      (b_in),
        .Data_in_C      (c_in),
`ifdef ADDSUB_EN
        .Data_in_Sub    (sub_in),
        .Data_out_Ovf   (ovf_out),
`endif
        .In_valid       (in_valid),
        .In_ready       (in_ready),
        .Data_out_Sum   (sum_out),
        .Data_out_Carry (carry_out),
        .Out_valid      (out_valid),
        .Out_ready      (out_ready)
    );

`ifndef ADDSUB_EN
    assign ovf_out = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum   = s;
        e.carry = c;
        e.ovf   = o;
        return e;
    endfunction

    // Reference model for the random vectors: a plain full-width add.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   s;
        exp_t         e;
        bb      = sub ? ~b : b;
        cc      = sub ? 1'b1 : c;
        s       = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        e.sum   = s[W-1:0];
        e.carry = s[W];
        e.ovf   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Downstream ready generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks the handshake, checks that a stalled output holds
    // steady, and pops the scoreboard on every output transfer.
    initial begin
        exp_t       e;
        logic       stalled;
        logic [W:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
                if (stalled) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'({carry_out, sum_out}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got sum %h expected no output (cycle %0d)",
                                 sum_out, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("sum", 32'(sum_out), 32'(e.sum));
                        check("carry", 32'(carry_out), 32'(e.carry));
`ifdef ADDSUB_EN
                        check("ovf", 32'(ovf_out), 32'(e.ovf));
`endif
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {carry_out, sum_out};
            end
        end
    end

    // Presents one token, holds it until it is accepted, and pushes the
    // expected result at the moment it is accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, input exp_t e);
        int guard;
        guard    = 0;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        sub_in   = sub;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                break;
            end
            guard++;
            if (guard > 1000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand(input logic sub);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom_range(0, 1));
        send(a, b, c, sub, model(a, b, c, sub));
    endtask

    // Call this right after send() returns on an empty pipeline with
    // Out_ready=1. n counts cycles, and the cycle in which the token was
    // presented counts as cycle 0.
    task automatic check_latency(input string name);
        int n;
        n = 1;
        forever begin
            @(negedge clk);
            if (out_valid || n > 50) break;
            n++;
            @(posedge clk);
        end
        check(name, 32'(n), 32'(STAGES));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rdy_mode = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        int t0;
        int o0;
        int outs_after_rst;
        rst      = 1'b1;
        a_in     = '0;
        b_in     = '0;
        c_in     = 1'b0;
        sub_in   = 1'b0;
        in_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDSUB_EN
        check("rst_ovf", 32'(ovf_out), 32'd0);
`endif
        rst = 1'b0;
        idle(1);

        // Single operations, each with its latency measured
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        check_latency("latency_00ff");
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        check_latency("latency_ripple");
        drain();

        // Back-to-back directed adds, each result worked out by hand
        send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        send(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1));
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'hABCD, 16'h1234, 1'b0, 1'b0, mk(16'hBE01, 1'b0, 1'b0));
        drain();

        // Reset mid-stream with 3 tokens in flight
        rdy_mode = 2;
        idle(2);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0));
        send(16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0));
        send(16'hF000, 16'h1000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        rdy_mode = 0;
        o0 = n_out;
        idle(12);
        outs_after_rst = n_out - o0;
        check("midrst_no_tokens", 32'(outs_after_rst), 32'd0);

        // Streaming: 100 random tokens back to back
        t0 = cyc;
        o0 = n_out;
        for (int i = 0; i < 100; i++) send_rand(1'b0);
        check("stream_issue_cycles", 32'(cyc - t0), 32'd100);
        drain();
        check("stream_out_count", 32'(n_out - o0), 32'd100);

        // Backpressure: random Out_ready and random In_valid
        rdy_mode = 1;
        o0 = n_out;
        t0 = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_rand(1'b0);
                t0++;
            end else begin
                idle(1);
            end
        end
        drain();
        check("bp_out_count", 32'(n_out - o0), 32'(t0));

`ifdef ADDSUB_EN
        // Add/sub: directed cases, then add and sub tokens interleaved back to back
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        check_latency("latency_sub");
        send(16'h0003, 16'h0005, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0));
        send(16'h0005, 16'h0003, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h0000, 16'h0001, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 1'b0));
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        drain();
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) send_rand(1'($urandom_range(0, 1)));
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
